// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with power-up clear sweep,
// write-first bypass and an optional hardwired zero entry.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 6,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wrt,
    input  logic [ADDR_W-1:0]     rd,
    input  logic [WIDTH-1:0]      din,
    input  logic [NRD*ADDR_W-1:0] rs,
    output logic [NRD*WIDTH-1:0]  sout,
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W:0]      r_clr_ptr;
    logic [ADDR_W:0]      w_clr_ptr_nxt;
    logic                 r_ready;
    logic                 w_ready_nxt;
    logic [NRD*WIDTH-1:0] r_sout;
    logic [NRD*WIDTH-1:0] w_sout_nxt;
    logic [WIDTH-1:0]     r_mem [DEPTH];

    logic                 w_last_clr;
    logic                 w_wr_qual;
    logic                 w_mem_we;
    logic [ADDR_W-1:0]    w_mem_addr;
    logic [WIDTH-1:0]     w_mem_wdata;

    assign w_last_clr = (r_clr_ptr == {1'b0, {ADDR_W{1'b1}}});
    assign w_wr_qual  = (r_state == ST_RUN) && wrt
                        && !(ZR && (rd == {ADDR_W{1'b0}}));

    // Next-state logic for the clear sweep and the ready flag
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_ready_nxt   = r_ready;
        case (r_state)
            ST_CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + {{ADDR_W{1'b0}}, 1'b1};
                if (w_last_clr) begin
                    w_state_nxt = ST_RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_ready_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_ptr_nxt = {(ADDR_W+1){1'b0}};
                w_ready_nxt   = 1'b0;
            end
        endcase
    end

    // Array write port: the sweep owns it in CLEAR, writeback owns it in RUN
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = rd;
        w_mem_wdata = din;
        if (!rst_n) begin
            w_mem_we = 1'b0;
        end else if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_ptr[ADDR_W-1:0];
            w_mem_wdata = {WIDTH{1'b0}};
        end else if (w_wr_qual) begin
            w_mem_we = 1'b1;
        end else begin
            w_mem_we = 1'b0;
        end
    end

    // Per-lane read resolution: zero entry, then same-edge bypass, then array
    always_comb begin
        w_sout_nxt = {(NRD*WIDTH){1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (r_state != ST_RUN) begin
                w_sout_nxt[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end else if (ZR && (rs[k*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}})) begin
                w_sout_nxt[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end else if (w_wr_qual && (rd == rs[k*ADDR_W +: ADDR_W])) begin
                w_sout_nxt[k*WIDTH +: WIDTH] = din;
            end else begin
                w_sout_nxt[k*WIDTH +: WIDTH] = r_mem[rs[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Control and output registers; reset restarts the sweep from entry 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= {(ADDR_W+1){1'b0}};
            r_ready   <= 1'b0;
            r_sout    <= {(NRD*WIDTH){1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_ready   <= w_ready_nxt;
            r_sout    <= w_sout_nxt;
        end
    end

    // Storage array; contents survive the reset edge itself
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign sout  = r_sout;
    assign ready = r_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default instance plus a 16-bit/8-entry/4-lane
// instance without the zero register.
module tb_regfile_mp;

    typedef struct packed {
        logic        chk;
        logic        rdy;
        logic [63:0] sout;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_na = 1'b0, wrt_a = 1'b0;
    logic [5:0]  rd_a   = 6'd0;
    logic [31:0] din_a  = 32'd0;
    logic [11:0] rs_a   = 12'd0;
    logic [63:0] sout_a;
    logic        ready_a;

    logic        rst_nb = 1'b0, wrt_b = 1'b0;
    logic [2:0]  rd_b   = 3'd0;
    logic [15:0] din_b  = 16'd0;
    logic [11:0] rs_b   = 12'd0;
    logic [63:0] sout_b;
    logic        ready_b;

    regfile_mp dut_a (
        .clk(clk), .rst_n(rst_na), .wrt(wrt_a), .rd(rd_a), .din(din_a),
        .rs(rs_a), .sout(sout_a), .ready(ready_a)
    );

    regfile_mp #(.WIDTH(16), .ADDR_W(3), .NRD(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_nb), .wrt(wrt_b), .rd(rd_b), .din(din_b),
        .rs(rs_b), .sout(sout_b), .ready(ready_b)
    );

    exp_t  qa[$];
    exp_t  qb[$];
    string qna[$];
    string qnb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    exp_t  ea, eb;
    string na, nb;

    // Monitor: one expectation per DUT per clock edge, sampled 1 unit after it
    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            na = qna.pop_front();
            if (ea.chk) begin
                n_cmp++;
                if ({ready_a, sout_a} !== {ea.rdy, ea.sout}) begin
                    n_bad++;
                    $display("FAIL A.%s: got ready=%b sout=%h, want ready=%b sout=%h",
                             na, ready_a, sout_a, ea.rdy, ea.sout);
                end
            end
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            nb = qnb.pop_front();
            if (eb.chk) begin
                n_cmp++;
                if ({ready_b, sout_b} !== {eb.rdy, eb.sout}) begin
                    n_bad++;
                    $display("FAIL B.%s: got ready=%b sout=%h, want ready=%b sout=%h",
                             nb, ready_b, sout_b, eb.rdy, eb.sout);
                end
            end
        end
    end

    task automatic cyc_a(input logic r, input logic w, input logic [5:0] a,
                         input logic [31:0] d, input logic [11:0] s,
                         input logic rdy, input logic [63:0] so, input string nm);
        exp_t e;
        rst_na = r; wrt_a = w; rd_a = a; din_a = d; rs_a = s;
        e.chk = 1'b1; e.rdy = rdy; e.sout = so;
        qa.push_back(e);
        qna.push_back(nm);
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic r, input logic w, input logic [2:0] a,
                         input logic [15:0] d, input logic [11:0] s,
                         input logic rdy, input logic [63:0] so, input string nm);
        exp_t e;
        rst_nb = r; wrt_b = w; rd_b = a; din_b = d; rs_b = s;
        e.chk = 1'b1; e.rdy = rdy; e.sout = so;
        qb.push_back(e);
        qnb.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Default instance: reset, sweep, and a write during CLEAR that must be dropped
        cyc_a(1'b0, 1'b0, 6'd0, 32'd0, {6'd5, 6'd3}, 1'b0, 64'd0, "reset1");
        cyc_a(1'b0, 1'b0, 6'd0, 32'd0, {6'd5, 6'd3}, 1'b0, 64'd0, "reset2");
        for (int i = 1; i <= 64; i++) begin
            cyc_a(1'b1, (i == 10), 6'd3, 32'h0000_AAAA, {6'd5, 6'd3},
                  (i == 64), 64'd0, "sweep");
        end
        cyc_a(1'b1, 1'b0, 6'd0, 32'd0, {6'd5, 6'd3}, 1'b1, 64'd0, "post_sweep_read");

        // Write then read
        cyc_a(1'b1, 1'b1, 6'd3, 32'h0000_0005, {6'd7, 6'd5}, 1'b1, 64'd0, "write3");
        cyc_a(1'b1, 1'b0, 6'd0, 32'd0, {6'd7, 6'd3}, 1'b1,
              64'h0000_0000_0000_0005, "read3");

        // Same-edge bypass on both lanes, then from the array
        cyc_a(1'b1, 1'b1, 6'd9, 32'hDEAD_BEEF, {6'd9, 6'd9}, 1'b1,
              64'hDEAD_BEEF_DEAD_BEEF, "bypass9");
        cyc_a(1'b1, 1'b0, 6'd0, 32'd0, {6'd9, 6'd3}, 1'b1,
              64'hDEAD_BEEF_0000_0005, "array9");

        // Zero register: write to entry 0 ignored and never bypassed
        cyc_a(1'b1, 1'b1, 6'd0, 32'hFFFF_FFFF, {6'd3, 6'd0}, 1'b1,
              64'h0000_0005_0000_0000, "zero_same");
        cyc_a(1'b1, 1'b0, 6'd0, 32'd0, {6'd0, 6'd0}, 1'b1, 64'd0, "zero_next");

        // Top address, one lane bypassed and one from the array
        cyc_a(1'b1, 1'b1, 6'd63, 32'h600D_F00D, {6'd63, 6'd9}, 1'b1,
              64'h600D_F00D_DEAD_BEEF, "top63");

        // Fill entry 10, then reset mid-operation and again mid-sweep
        cyc_a(1'b1, 1'b1, 6'd10, 32'h0000_1234, {6'd10, 6'd10}, 1'b1,
              64'h0000_1234_0000_1234, "fill10");
        cyc_a(1'b1, 1'b0, 6'd0, 32'd0, {6'd10, 6'd0}, 1'b1,
              64'h0000_1234_0000_0000, "read10");
        cyc_a(1'b0, 1'b0, 6'd0, 32'd0, {6'd63, 6'd10}, 1'b0, 64'd0, "reset_run");
        for (int i = 1; i <= 20; i++) begin
            cyc_a((i != 20), 1'b0, 6'd0, 32'd0, {6'd63, 6'd10}, 1'b0, 64'd0,
                  "sweep_abort");
        end
        for (int i = 1; i <= 64; i++) begin
            cyc_a(1'b1, 1'b0, 6'd0, 32'd0, {6'd63, 6'd10}, (i == 64), 64'd0,
                  "resweep");
        end
        cyc_a(1'b1, 1'b0, 6'd0, 32'd0, {6'd63, 6'd10}, 1'b1, 64'd0, "read10_cleared");

        // Narrow instance: 8-edge sweep, fill 1..7, 4-lane read
        cyc_b(1'b0, 1'b0, 3'd0, 16'd0, 12'd0, 1'b0, 64'd0, "reset");
        for (int i = 1; i <= 8; i++) begin
            cyc_b(1'b1, 1'b0, 3'd0, 16'd0, 12'd0, (i == 8), 64'd0, "sweep");
        end
        for (int i = 1; i <= 7; i++) begin
            cyc_b(1'b1, 1'b1, 3'(i), 16'h1000 + 16'(i), 12'd0, 1'b1, 64'd0, "fill");
        end
        cyc_b(1'b1, 1'b0, 3'd0, 16'd0, {3'd0, 3'd1, 3'd6, 3'd7}, 1'b1,
              64'h0000_1001_1006_1007, "read4");

        // No zero register: entry 0 is ordinary storage with bypass
        cyc_b(1'b1, 1'b1, 3'd0, 16'hFFFF, 12'd0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, "zero_bypass");
        cyc_b(1'b1, 1'b0, 3'd0, 16'd0, 12'd0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, "zero_array");
        cyc_b(1'b1, 1'b1, 3'd7, 16'hBEEF, {3'd0, 3'd1, 3'd6, 3'd7}, 1'b1,
              64'hFFFF_1001_1006_BEEF, "lane0_bypass");

        wrt_b = 1'b0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
